lsu_mem_initiator: RTL and testbench

- Initiator side of the data-memory interface, placed in the MEM stage between the pipeline and the 64-bit word-addressed data memory.
- Accepts one load/store at a time from the pipeline and performs all RISC-V sub-word handling: byte lane extraction, sign/zero extension, and read-modify-write for SB/SH/SW.
- Rejects misaligned accesses.
- Holds the pipeline through `busy` until a one-cycle response is produced.

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/lsu_lane_align.sv | 53 +++++
 rtl/lsu_mem_initiator.sv | 126 ++++++++++++
 tb/tb_lsu_mem_initiator.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the LSU memory initiator: access sizes, FSM states
// and the alignment rule applied when a request is captured.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  // state      | meaning
  // ST_IDLE    | ready for a new request
  // ST_RD_REQ  | read request presented to memory (load or RMW read)
  // ST_RD_WAIT | waiting for read data
  // ST_WR_REQ  | write request presented to memory
  // ST_RESP    | one-cycle completion pulse
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_REQ  = 3'd1;
  localparam logic [2:0] ST_RD_WAIT = 3'd2;
  localparam logic [2:0] ST_WR_REQ  = 3'd3;
  localparam logic [2:0] ST_RESP    = 3'd4;

  typedef struct packed {
    logic       write;
    logic [1:0] size;
    logic       uns;
  } req_attr_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] addr_lo);
    logic mis;
    case (size)
      SZ_H:    mis = addr_lo[0];
      SZ_W:    mis = |addr_lo[1:0];
      SZ_D:    mis = |addr_lo;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for one memory word: extended load extraction and
// store-data merge for read-modify-write.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] word_i,
  input  logic [2:0]      offset_i,
  input  logic [1:0]      size_i,
  input  logic            uns_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] load_o,
  output logic [XLEN-1:0] merged_o
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] base_mask;
  logic [XLEN-1:0] lane_mask;

  assign shamt   = SHW'({offset_i, 3'b000});
  assign shifted = word_i >> shamt;

  always_comb begin
    load_o    = shifted;
    base_mask = '1;
    case (size_i)
      SZ_B: begin
        load_o    = {{(XLEN-8){~uns_i & shifted[7]}}, shifted[7:0]};
        base_mask = XLEN'(8'hFF);
      end
      SZ_H: begin
        load_o    = {{(XLEN-16){~uns_i & shifted[15]}}, shifted[15:0]};
        base_mask = XLEN'(16'hFFFF);
      end
      SZ_W: begin
        load_o    = {{(XLEN-32){~uns_i & shifted[31]}}, shifted[31:0]};
        base_mask = XLEN'(32'hFFFF_FFFF);
      end
      default: begin
        load_o    = shifted;
        base_mask = '1;
      end
    endcase
  end

  assign lane_mask = base_mask << shamt;
  assign merged_o  = (word_i & ~lane_mask) | ((wdata_i << shamt) & lane_mask);

endmodule

// File: rtl/lsu_mem_initiator.sv
// MEM-stage initiator: one load/store at a time against a word-addressed
// data memory, with sub-word extraction, RMW stores and misalignment errors.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [XLEN-1:0]   req_addr_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  output logic              resp_valid_o,
  output logic [XLEN-1:0]   resp_rdata_o,
  output logic              resp_err_o,
  output logic              busy_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i
);

  logic [2:0]        state_q, state_d;
  req_attr_t         attr_q, attr_d;
  logic [2:0]        off_q, off_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [XLEN-1:0]   load_val;
  logic [XLEN-1:0]   merged_word;
  logic              unused_addr_hi;

  // Address bits above the word index wrap silently.
  assign unused_addr_hi = ^req_addr_i[XLEN-1:ADDR_W+3];

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .word_i   (mem_rdata_i),
    .offset_i (off_q),
    .size_i   (attr_q.size),
    .uns_i    (attr_q.uns),
    .wdata_i  (data_q),
    .load_o   (load_val),
    .merged_o (merged_word)
  );

  always_comb begin
    state_d = state_q;
    attr_d  = attr_q;
    off_d   = off_q;
    waddr_d = waddr_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          attr_d  = '{write: req_write_i, size: req_size_i, uns: req_unsigned_i};
          off_d   = req_addr_i[2:0];
          waddr_d = req_addr_i[ADDR_W+2:3];
          data_d  = req_wdata_i;
          rdata_d = '0;
          err_d   = is_misaligned(req_size_i, req_addr_i[2:0]);
          if (err_d)                                 state_d = ST_RESP;
          else if (req_write_i && req_size_i == SZ_D) state_d = ST_WR_REQ;
          else                                       state_d = ST_RD_REQ;
        end
      end
      ST_RD_REQ: if (mem_req_ready_i) state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (mem_rvalid_i) begin
          if (attr_q.write) begin
            data_d  = merged_word;
            state_d = ST_WR_REQ;
          end else begin
            rdata_d = load_val;
            state_d = ST_RESP;
          end
        end
      end
      ST_WR_REQ: if (mem_req_ready_i) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      attr_q  <= '0;
      off_q   <= '0;
      waddr_q <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      attr_q  <= attr_d;
      off_q   <= off_d;
      waddr_q <= waddr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o     = (state_q == ST_IDLE);
  assign busy_o          = (state_q != ST_IDLE);
  assign mem_req_valid_o = (state_q == ST_RD_REQ) || (state_q == ST_WR_REQ);
  assign mem_we_o        = (state_q == ST_WR_REQ);
  assign mem_addr_o      = waddr_q;
  assign mem_wdata_o     = data_q;
  assign resp_valid_o    = (state_q == ST_RESP);
  assign resp_rdata_o    = (state_q == ST_RESP) ? rdata_q : '0;
  assign resp_err_o      = (state_q == ST_RESP) && err_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Randomized bench for lsu_mem_initiator against a byte-array memory model,
// with a reactive memory responder and directed corner cases.
module tb_lsu_mem_initiator;

  localparam int XLEN   = 64;
  localparam int ADDR_W = 10;
  localparam int NW     = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0, req_ready, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0]        req_size = '0;
  logic [XLEN-1:0]   req_addr = '0, req_wdata = '0;
  logic              resp_valid, resp_err, busy;
  logic [XLEN-1:0]   resp_rdata;
  logic              mem_req_valid, mem_req_ready, mem_we, mem_rvalid;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  lsu_mem_initiator #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata),
    .resp_err_o(resp_err), .busy_o(busy), .mem_req_valid_o(mem_req_valid),
    .mem_req_ready_i(mem_req_ready), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );

  int n_cmp = 0, n_fail = 0, cyc = 0;
  logic [63:0] mem_model [NW];
  logic [7:0]  ref_bytes [NW*8];

  logic        in_flight = 1'b0;
  int          hs_cyc = 0, exp_lat = -1, resp_count = 0;
  logic [63:0] exp_rdata = '0;
  logic        exp_err = 1'b0;
  logic        exp_wr_valid = 1'b0;
  logic [9:0]  exp_wr_addr = '0;
  logic [63:0] exp_wr_data = '0;
  int          n_reads = 0, n_writes = 0, n_memvalid = 0;
  int          stall_left = 0, rd_delay_fix = -1;
  logic        zero_wait = 1'b1;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_word(input int idx, input logic [63:0] v);
    mem_model[idx] = v;
    for (int j = 0; j < 8; j++) ref_bytes[idx*8 + j] = v[8*j +: 8];
  endtask

  function automatic logic [63:0] model_load(input logic [1:0] sz, input logic uns,
                                             input logic [63:0] addr);
    int n, base;
    logic [63:0] v;
    n    = 1 << sz;
    base = int'(addr[12:0]);
    v    = '0;
    for (int i = 0; i < n; i++) v |= 64'(ref_bytes[base + i]) << (8 * i);
    if (!uns && n < 8 && v[8*n-1]) v |= ~((64'd1 << (8 * n)) - 64'd1);
    return v;
  endfunction

  // Compare process: handshake tracking, busy/ready, and every response.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        in_flight = 1'b0;
      end else begin
        check64("busy", 64'(busy), 64'(in_flight));
        check64("req_ready", 64'(req_ready), 64'(!in_flight));
        if (resp_valid) begin
          if (!in_flight) begin
            check64("unexpected_resp", 64'(resp_valid), 64'd0);
          end else begin
            check64("resp_rdata", resp_rdata, exp_rdata);
            check64("resp_err", 64'(resp_err), 64'(exp_err));
            if (exp_lat >= 0) check_int("latency", cyc - hs_cyc, exp_lat);
            resp_count++;
            in_flight = 1'b0;
          end
        end else begin
          check64("resp_err_idle", 64'(resp_err), 64'd0);
          if (!in_flight && req_valid && req_ready) begin
            in_flight = 1'b1;
            hs_cyc    = cyc;
          end
        end
      end
    end
  end

  // Memory responder: random/scripted ready, delayed read data, write capture.
  initial begin
    logic hs, we, prev_stall, rd_pend;
    logic [ADDR_W-1:0] a, p_addr, rd_addr;
    logic [63:0] d, p_wdata;
    logic p_we;
    int rd_cnt;
    prev_stall = 1'b0; rd_pend = 1'b0; rd_cnt = 0; rd_addr = '0;
    p_addr = '0; p_wdata = '0; p_we = 1'b0;
    mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      hs = mem_req_valid && mem_req_ready;
      we = mem_we; a = mem_addr; d = mem_wdata;
      if (mem_req_valid) n_memvalid++;
      if (prev_stall && rst_n) begin
        check64("mem_valid_hold", 64'(mem_req_valid), 64'd1);
        check64("mem_addr_hold", 64'(mem_addr), 64'(p_addr));
        check64("mem_we_hold", 64'(mem_we), 64'(p_we));
        if (p_we) check64("mem_wdata_hold", mem_wdata, p_wdata);
      end
      prev_stall = rst_n && mem_req_valid && !mem_req_ready;
      p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata;
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      mem_rdata  = {$urandom, $urandom};
      if (hs) begin
        if (we) begin
          n_writes++;
          if (!exp_wr_valid) begin
            check64("unexpected_write", 64'd1, 64'd0);
          end else begin
            check64("wr_addr", 64'(a), 64'(exp_wr_addr));
            check64("wr_data", d, exp_wr_data);
          end
          exp_wr_valid = 1'b0;
          mem_model[a] = d;
        end else begin
          n_reads++;
          rd_pend = 1'b1;
          rd_addr = a;
          rd_cnt  = (rd_delay_fix >= 0) ? rd_delay_fix : (zero_wait ? 0 : int'($urandom_range(0, 2)));
        end
      end
      if (rd_pend) begin
        if (rd_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_model[rd_addr];
          rd_pend    = 1'b0;
        end else begin
          rd_cnt--;
        end
      end else if (!zero_wait && $urandom_range(0, 7) == 0) begin
        mem_rvalid = 1'b1;
      end
      if (mem_req_valid && stall_left > 0) begin
        mem_req_ready = 1'b0;
        stall_left--;
      end else begin
        mem_req_ready = zero_wait ? 1'b1 : 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic do_txn(input logic w, input logic [1:0] sz, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wd, input logic chk_lat);
    int n, base, r0, w0, v0, rc0, cnt, er, ew;
    logic mis;
    n    = 1 << sz;
    base = int'(addr[12:0]);
    mis  = (addr % 64'(n)) != 0;
    if (mis) begin
      exp_rdata = '0; exp_err = 1'b1;
    end else if (!w) begin
      exp_rdata = model_load(sz, uns, addr); exp_err = 1'b0;
    end else begin
      for (int i = 0; i < n; i++) ref_bytes[base + i] = wd[8*i +: 8];
      exp_rdata   = '0; exp_err = 1'b0;
      exp_wr_addr = addr[12:3];
      for (int j = 0; j < 8; j++) exp_wr_data[8*j +: 8] = ref_bytes[int'({addr[12:3], 3'b000}) + j];
      exp_wr_valid = 1'b1;
    end
    exp_lat = !chk_lat ? -1 : mis ? 1 : !w ? 3 : (sz == 2'd3) ? 2 : 4;
    er = mis ? 0 : (w && sz == 2'd3) ? 0 : 1;
    ew = (mis || !w) ? 0 : 1;
    r0 = n_reads; w0 = n_writes; v0 = n_memvalid; rc0 = resp_count;
    req_write = w; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr  = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    cnt = 0;
    while (resp_count == rc0 && cnt < 300) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check_int("resp_seen", resp_count - rc0, 1);
    check_int("mem_reads", n_reads - r0, er);
    check_int("mem_writes", n_writes - w0, ew);
    if (mis) check_int("misaligned_mem_valid", n_memvalid - v0, 0);
    exp_wr_valid = 1'b0;
  endtask

  initial begin
    int r0, w0, rc0, cnt;
    logic [1:0] sz;
    logic [63:0] a;
    for (int i = 0; i < NW; i++) set_word(i, {$urandom, $urandom});
    repeat (2) @(posedge clk);
    #1;
    check64("rst_req_ready", 64'(req_ready), 64'd1);
    check64("rst_busy", 64'(busy), 64'd0);
    check64("rst_resp_valid", 64'(resp_valid), 64'd0);
    check64("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    check64("rst_mem_we", 64'(mem_we), 64'd0);
    check64("rst_mem_addr", 64'(mem_addr), 64'd0);
    check64("rst_mem_wdata", mem_wdata, 64'd0);
    check64("rst_resp_rdata", resp_rdata, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // LB / LBU on a sign-bit byte
    set_word(1, 64'h0000_0000_8000_0000);
    check64("model_lb", model_load(2'd0, 1'b0, 64'h0B), 64'hFFFF_FFFF_FFFF_FF80);
    check64("model_lbu", model_load(2'd0, 1'b1, 64'h0B), 64'h0000_0000_0000_0080);
    do_txn(1'b0, 2'd0, 1'b0, 64'h0B, '0, 1'b1);
    do_txn(1'b0, 2'd0, 1'b1, 64'h0B, '0, 1'b1);

    // SH read-modify-write
    set_word(2, 64'h1111_1111_1111_1111);
    do_txn(1'b1, 2'd1, 1'b0, 64'h12, 64'h0000_0000_0000_BEEF, 1'b1);
    check64("sh_word", mem_model[2], 64'h1111_1111_BEEF_1111);

    // SD direct write
    do_txn(1'b1, 2'd3, 1'b0, 64'h20, 64'hDEAD_BEEF_0123_4567, 1'b1);
    check64("sd_word", mem_model[4], 64'hDEAD_BEEF_0123_4567);

    // Misaligned LW
    do_txn(1'b0, 2'd2, 1'b0, 64'h06, '0, 1'b1);

    // LD under stalls: ready low 3 cycles, read data 2 cycles late
    stall_left = 3; rd_delay_fix = 2;
    do_txn(1'b0, 2'd3, 1'b0, 64'h38, '0, 1'b0);
    rd_delay_fix = -1;
    repeat (4) @(posedge clk);
    #1;

    // Reset during RD_WAIT of an SB; stale rvalid arrives afterwards
    rd_delay_fix = 2;
    r0 = n_reads; w0 = n_writes; rc0 = resp_count;
    req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 64'h2B; req_wdata = 64'hAA; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    cnt = 0;
    while (n_reads == r0 && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check_int("rst_test_read_issued", n_reads - r0, 1);
    #1 rst_n = 1'b0;
    #6 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check64("post_rst_busy", 64'(busy), 64'd0);
    check64("post_rst_req_ready", 64'(req_ready), 64'd1);
    repeat (8) @(posedge clk);
    #1;
    check_int("post_rst_writes", n_writes - w0, 0);
    check_int("post_rst_resp", resp_count - rc0, 0);
    rd_delay_fix = -1;

    // Randomized traffic: zero-wait first (latency checked), then random waits
    for (int t = 0; t < 240; t++) begin
      zero_wait = (t < 80);
      sz = 2'($urandom);
      a  = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a = a & ~64'((1 << sz) - 1);
      do_txn(1'($urandom), sz, 1'($urandom), a, {$urandom, $urandom}, zero_wait);
    end
    zero_wait = 1'b1;
    repeat (4) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
